// File: rtl/pipelined_control_sequencer.sv
// Pipelined control sequencer: ID/EX/MEM/WB control slots whose registered
// contents are OR-ed into one control bus, with stall, flush and MEM hold.
package pcs_pkg;
  localparam int OPCODE_COUNT = 16;
  localparam int TYPE_NOP   = 0;
  localparam int TYPE_ADD   = 1;
  localparam int TYPE_SUB   = 2;
  localparam int TYPE_MOV   = 3;
  localparam int TYPE_LD    = 4;
  localparam int TYPE_LDI   = 5;
  localparam int TYPE_ST    = 6;
  localparam int TYPE_STI   = 7;
  localparam int TYPE_PUSH  = 8;
  localparam int TYPE_POP   = 9;
  localparam int TYPE_RCALL = 10;
  localparam int TYPE_RET   = 11;
  localparam int TYPE_IN    = 12;
  localparam int TYPE_OUT   = 13;
  localparam int TYPE_AUX   = 14;
  localparam int TYPE_JMP   = 15;

  localparam int GROUP_COUNT        = 11;
  localparam int GRP_ALU            = 0;
  localparam int GRP_ALU_TWO_OP     = 1;
  localparam int GRP_ALU_AUX        = 2;
  localparam int GRP_REGISTER       = 3;
  localparam int GRP_LOAD           = 4;
  localparam int GRP_STORE          = 5;
  localparam int GRP_LOAD_INDIRECT  = 6;
  localparam int GRP_STORE_INDIRECT = 7;
  localparam int GRP_STACK          = 8;
  localparam int GRP_IO_READ        = 9;
  localparam int GRP_IO_WRITE       = 10;

  localparam int SIGNAL_COUNT          = 9;
  localparam int CONTROL_REG_RR_READ   = 0;
  localparam int CONTROL_REG_RD_READ   = 1;
  localparam int CONTROL_REG_RD_WRITE  = 2;
  localparam int CONTROL_MEM_READ      = 3;
  localparam int CONTROL_MEM_WRITE     = 4;
  localparam int CONTROL_IO_READ       = 5;
  localparam int CONTROL_IO_WRITE      = 6;
  localparam int CONTROL_POSTDEC       = 7;
  localparam int CONTROL_PREINC        = 8;
endpackage

module pipelined_control_sequencer
  import pcs_pkg::*;
#(
  parameter int OPC_W          = OPCODE_COUNT,
  parameter int GRP_W          = GROUP_COUNT,
  parameter int SIG_W          = SIGNAL_COUNT,
  parameter int RET_MEM_CYCLES = 2,
  parameter int CNT_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode_type,
  input  logic [GRP_W-1:0] in_opcode_group,
  input  logic             stall,
  input  logic             flush,
  output logic [SIG_W-1:0] signals,
  output logic [3:0]       stage_valid,
  output logic [CNT_W-1:0] mem_cycle,
  output logic             retire
);

  // slot index: 0=ID 1=EX 2=MEM 3=WB
  logic [3:0]       v_q, v_d;
  logic [OPC_W-1:0] t_q [4];
  logic [OPC_W-1:0] t_d [4];
  logic [GRP_W-1:0] g_q [4];
  logic [GRP_W-1:0] g_d [4];
  logic [CNT_W-1:0] mc_q, mc_d;

  logic mem_multi, mem_hold, xfer;
  logic sel_fl, sel_hold, sel_stall;

  assign mem_multi = v_q[2] &&
                     (t_q[2][TYPE_RET] || t_q[2][TYPE_RCALL]);
  assign mem_hold  = mem_multi &&
                     (mc_q != CNT_W'(RET_MEM_CYCLES - 1));
  assign in_ready  = !stall && !mem_hold && !flush;
  assign xfer      = in_valid && in_ready;

  assign sel_fl    = flush;
  assign sel_hold  = !flush && mem_hold;
  assign sel_stall = !flush && !mem_hold && stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q  <= '0;
      t_q  <= '{default: '0};
      g_q  <= '{default: '0};
      mc_q <= '0;
    end else begin
      v_q  <= v_d;
      t_q  <= t_d;
      g_q  <= g_d;
      mc_q <= mc_d;
    end
  end

  always_comb begin
    v_d  = v_q;
    t_d  = t_q;
    g_d  = g_q;
    mc_d = mc_q;
    unique case (1'b1)
      sel_fl: begin
        v_d[1:0] = 2'b00;
        if (mem_hold) begin
          mc_d   = mc_q + CNT_W'(1);
          v_d[3] = 1'b0;
        end else begin
          v_d[3] = v_q[2];
          t_d[3] = t_q[2];
          g_d[3] = g_q[2];
          v_d[2] = 1'b0;
          mc_d   = '0;
        end
      end
      sel_hold: begin
        mc_d   = mc_q + CNT_W'(1);
        v_d[3] = 1'b0;
      end
      sel_stall: begin
        v_d[3] = v_q[2];
        t_d[3] = t_q[2];
        g_d[3] = g_q[2];
        v_d[2] = v_q[1];
        t_d[2] = t_q[1];
        g_d[2] = g_q[1];
        v_d[1] = 1'b0;
        mc_d   = '0;
      end
      default: begin
        for (int i = 3; i > 0; i--) begin
          v_d[i] = v_q[i-1];
          t_d[i] = t_q[i-1];
          g_d[i] = g_q[i-1];
        end
        v_d[0] = xfer;
        t_d[0] = in_opcode_type;
        g_d[0] = in_opcode_group;
        mc_d   = '0;
      end
    endcase
  end

  always_comb begin
    signals = '0;
    signals[CONTROL_REG_RR_READ] = v_q[0] &&
      (g_q[0][GRP_ALU_TWO_OP] || g_q[0][GRP_LOAD_INDIRECT] ||
       g_q[0][GRP_STORE] || t_q[0][TYPE_MOV] || t_q[0][TYPE_OUT]);
    signals[CONTROL_REG_RD_READ] = v_q[0] &&
      (g_q[0][GRP_ALU] ||
       ((g_q[0][GRP_STORE_INDIRECT] || g_q[0][GRP_LOAD_INDIRECT]) &&
        !g_q[0][GRP_STACK]));
    signals[CONTROL_REG_RD_WRITE] = v_q[3] &&
      (g_q[3][GRP_ALU] || g_q[3][GRP_REGISTER] ||
       (g_q[3][GRP_LOAD] && !t_q[3][TYPE_RET]) || t_q[3][TYPE_IN]);
    signals[CONTROL_MEM_READ]  = v_q[2] && g_q[2][GRP_LOAD];
    signals[CONTROL_MEM_WRITE] = v_q[2] && g_q[2][GRP_STORE];
    signals[CONTROL_IO_READ]   = v_q[0] && g_q[0][GRP_IO_READ];
    // ALU_AUX ops drive IO_WRITE from EX only, never from WB
    signals[CONTROL_IO_WRITE] =
      (v_q[3] && g_q[3][GRP_IO_WRITE] && !g_q[3][GRP_ALU_AUX]) ||
      (v_q[1] && g_q[1][GRP_ALU_AUX]);
    signals[CONTROL_POSTDEC] = v_q[2] &&
      (t_q[2][TYPE_PUSH] || t_q[2][TYPE_RCALL]);
    signals[CONTROL_PREINC] =
      (v_q[1] && (t_q[1][TYPE_POP] || t_q[1][TYPE_RET])) ||
      (v_q[2] && t_q[2][TYPE_RET] && (mc_q == '0));
  end

  logic unused_bits;
  assign unused_bits = ^{t_q[0], t_q[1], t_q[2], t_q[3],
                         g_q[0], g_q[1], g_q[2], g_q[3]};

  assign stage_valid = v_q;
  assign mem_cycle   = mc_q;
  assign retire      = v_q[3];

endmodule

// File: tb/tb_pipelined_control_sequencer.sv
// Directed vector bench for pipelined_control_sequencer: per-cycle table
// of inputs and expected outputs, plus a mid-pipeline reset sequence.
module tb_pipelined_control_sequencer;
  import pcs_pkg::*;

  localparam int OPC_W = OPCODE_COUNT;
  localparam int GRP_W = GROUP_COUNT;
  localparam int SIG_W = SIGNAL_COUNT;
  localparam int CNT_W = 2;

  typedef logic [OPC_W-1:0] opc_t;
  typedef logic [GRP_W-1:0] grp_t;
  typedef logic [SIG_W-1:0] sig_t;

  localparam opc_t T_ADD   = OPC_W'(1) << TYPE_ADD;
  localparam opc_t T_RET   = OPC_W'(1) << TYPE_RET;
  localparam opc_t T_RCALL = OPC_W'(1) << TYPE_RCALL;
  localparam opc_t T_LD    = OPC_W'(1) << TYPE_LD;
  localparam opc_t T_OUT   = OPC_W'(1) << TYPE_OUT;
  localparam opc_t T_AUX   = OPC_W'(1) << TYPE_AUX;

  localparam grp_t G_ADD =
    (GRP_W'(1) << GRP_ALU) | (GRP_W'(1) << GRP_ALU_TWO_OP);
  localparam grp_t G_RET =
    (GRP_W'(1) << GRP_LOAD) | (GRP_W'(1) << GRP_STACK);
  localparam grp_t G_RCALL =
    (GRP_W'(1) << GRP_STORE) | (GRP_W'(1) << GRP_STACK);
  localparam grp_t G_LD  = GRP_W'(1) << GRP_LOAD;
  localparam grp_t G_OUT = GRP_W'(1) << GRP_IO_WRITE;
  localparam grp_t G_AUX =
    (GRP_W'(1) << GRP_ALU_AUX) | (GRP_W'(1) << GRP_IO_WRITE);

  localparam sig_t S_RR   = SIG_W'(1) << CONTROL_REG_RR_READ;
  localparam sig_t S_RDR  = SIG_W'(1) << CONTROL_REG_RD_READ;
  localparam sig_t S_RDW  = SIG_W'(1) << CONTROL_REG_RD_WRITE;
  localparam sig_t S_MR   = SIG_W'(1) << CONTROL_MEM_READ;
  localparam sig_t S_MW   = SIG_W'(1) << CONTROL_MEM_WRITE;
  localparam sig_t S_IOW  = SIG_W'(1) << CONTROL_IO_WRITE;
  localparam sig_t S_POST = SIG_W'(1) << CONTROL_POSTDEC;
  localparam sig_t S_PRE  = SIG_W'(1) << CONTROL_PREINC;

  typedef struct {
    logic       v;
    opc_t       t;
    grp_t       g;
    logic       st;
    logic       fl;
    sig_t       sig;
    logic [3:0] sv;
    logic       rdy;
    logic       ret;
    logic [1:0] mc;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  opc_t             in_opcode_type;
  grp_t             in_opcode_group;
  logic             stall;
  logic             flush;
  sig_t             signals;
  logic [3:0]       stage_valid;
  logic [CNT_W-1:0] mem_cycle;
  logic             retire;

  int tests = 0;
  int fails = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  pipelined_control_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode_type  (in_opcode_type),
    .in_opcode_group (in_opcode_group),
    .stall           (stall),
    .flush           (flush),
    .signals         (signals),
    .stage_valid     (stage_valid),
    .mem_cycle       (mem_cycle),
    .retire          (retire)
  );

  function automatic vec_t row(
    logic v, opc_t t, grp_t g, logic st, logic fl,
    sig_t sig, logic [3:0] sv, logic rdy, logic ret,
    logic [1:0] mc);
    vec_t r;
    r.v = v; r.t = t; r.g = g; r.st = st; r.fl = fl;
    r.sig = sig; r.sv = sv; r.rdy = rdy; r.ret = ret;
    r.mc = mc;
    return r;
  endfunction

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic v, opc_t t, grp_t g,
                       logic st, logic fl);
    in_valid        = v;
    in_opcode_type  = t;
    in_opcode_group = g;
    stall           = st;
    flush           = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, '0, '0, 0, 0);

    // 4 back-to-back ADDs
    tv.push_back(row(1, T_ADD, G_ADD, 0, 0, '0, 4'b0000, 1, 0, 0));
    tv.push_back(row(1, T_ADD, G_ADD, 0, 0, S_RR|S_RDR, 4'b0001, 1, 0, 0));
    tv.push_back(row(1, T_ADD, G_ADD, 0, 0, S_RR|S_RDR, 4'b0011, 1, 0, 0));
    tv.push_back(row(1, T_ADD, G_ADD, 0, 0, S_RR|S_RDR, 4'b0111, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RR|S_RDR|S_RDW, 4'b1111, 1, 1, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RDW, 4'b1110, 1, 1, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RDW, 4'b1100, 1, 1, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RDW, 4'b1000, 1, 1, 0));
    // RET then ADD, two MEM cycles for RET
    tv.push_back(row(1, T_RET, G_RET, 0, 0, '0, 4'b0000, 1, 0, 0));
    tv.push_back(row(1, T_ADD, G_ADD, 0, 0, '0, 4'b0001, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RR|S_RDR|S_PRE, 4'b0011, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_MR|S_PRE, 4'b0110, 0, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_MR, 4'b0110, 1, 0, 1));
    tv.push_back(row(0, '0, '0, 0, 0, '0, 4'b1100, 1, 1, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RDW, 4'b1000, 1, 1, 0));
    // ALU_AUX then OUT
    tv.push_back(row(1, T_AUX, G_AUX, 0, 0, '0, 4'b0000, 1, 0, 0));
    tv.push_back(row(1, T_OUT, G_OUT, 0, 0, '0, 4'b0001, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RR|S_IOW, 4'b0011, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, '0, 4'b0110, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, '0, 4'b1100, 1, 1, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_IOW, 4'b1000, 1, 1, 0));
    // LD held in ID by a 2-cycle stall
    tv.push_back(row(1, T_LD, G_LD, 0, 0, '0, 4'b0000, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 1, 0, '0, 4'b0001, 0, 0, 0));
    tv.push_back(row(0, '0, '0, 1, 0, '0, 4'b0001, 0, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, '0, 4'b0001, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, '0, 4'b0010, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_MR, 4'b0100, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_RDW, 4'b1000, 1, 1, 0));
    // flush while RCALL sits in MEM cycle 0
    tv.push_back(row(1, T_RCALL, G_RCALL, 0, 0, '0, 4'b0000, 1, 0, 0));
    tv.push_back(row(1, T_ADD, G_ADD, 0, 0, S_RR, 4'b0001, 1, 0, 0));
    tv.push_back(row(1, T_ADD, G_ADD, 0, 0, S_RR|S_RDR, 4'b0011, 1, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 1, S_RR|S_RDR|S_MW|S_POST, 4'b0111, 0, 0, 0));
    tv.push_back(row(0, '0, '0, 0, 0, S_MW|S_POST, 4'b0100, 1, 0, 1));
    tv.push_back(row(0, '0, '0, 0, 0, '0, 4'b1000, 1, 1, 0));
    tv.push_back(row(0, '0, '0, 0, 0, '0, 4'b0000, 1, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    chk("rst_sig", -1, 32'(signals), 32'(0));
    chk("rst_valid", -1, 32'(stage_valid), 32'(0));
    chk("rst_retire", -1, 32'(retire), 32'(0));
    chk("rst_ready", -1, 32'(in_ready), 32'(1));
    @(negedge clk);
    reset = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].t, tv[i].g, tv[i].st, tv[i].fl);
      #1;
      chk("signals", i, 32'(signals), 32'(tv[i].sig));
      chk("stage_valid", i, 32'(stage_valid), 32'(tv[i].sv));
      chk("in_ready", i, 32'(in_ready), 32'(tv[i].rdy));
      chk("retire", i, 32'(retire), 32'(tv[i].ret));
      chk("mem_cycle", i, 32'(mem_cycle), 32'(tv[i].mc));
    end

    // mid-pipeline reset with three valid slots
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, T_ADD, G_ADD, 0, 0);
    end
    @(negedge clk);
    drive(0, '0, '0, 0, 0);
    #1;
    chk("pre_rst_valid", 100, 32'(stage_valid), 32'(4'b0111));
    reset = 1'b0;
    #1;
    chk("mid_rst_sig", 101, 32'(signals), 32'(0));
    chk("mid_rst_valid", 101, 32'(stage_valid), 32'(0));
    chk("mid_rst_retire", 101, 32'(retire), 32'(0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("in_rst_retire", 102 + k, 32'(retire), 32'(0));
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_retire", 110 + k, 32'(retire), 32'(0));
      chk("post_rst_valid", 110 + k, 32'(stage_valid), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
